// File: rtl/elevator_request_ctrl.sv
// elevator_request_ctrl
//
// Request latch and SCAN dispatcher for a single elevator car.
// It remembers which floors have been called, tracks the car position
// from floor_tick pulses, picks a travel direction while the car is idle,
// tells the elevator FSM when the car has arrived at its target, and
// times the door dwell.
//
// Parameters
//   NUM_FLOORS   number of served floors (2..16)
//   FW           floor index width, ceil(log2(NUM_FLOORS))
//   DOOR_CYCLES  door dwell in clk cycles (>= 2)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   req          floor call buttons, bit i requests floor i
//   floor_tick   one-cycle pulse: car reached the next floor in its travel direction
//   door_hold    door-hold button, level-sensitive, restarts the dwell
//   motor_up     feedback: car is driving up
//   motor_down   feedback: car is driving down
//   door_open    feedback: door is open
//   UP           command: start travelling up (idle only)
//   DOWN         command: start travelling down (idle only)
//   EQ           status: moving car is at its target floor
//   T            status: door dwell has expired
//   cur_floor    current floor index
//   pending      latched outstanding requests

module elevator_request_ctrl #(
    parameter int NUM_FLOORS  = 4,
    parameter int FW          = 2,
    parameter int DOOR_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] req,
    input  logic                  floor_tick,
    input  logic                  door_hold,
    input  logic                  motor_up,
    input  logic                  motor_down,
    input  logic                  door_open,
    output logic                  UP,
    output logic                  DOWN,
    output logic                  EQ,
    output logic                  T,
    output logic [FW-1:0]         cur_floor,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int               CW        = $clog2(DOOR_CYCLES);
    localparam logic [CW-1:0]    CNT_MAX   = CW'(DOOR_CYCLES - 1);
    localparam logic [FW-1:0]    TOP_FLOOR = FW'(NUM_FLOORS - 1);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    dir_t                  dir, dir_next;
    logic [FW-1:0]         target, target_next;
    logic                  target_valid, target_valid_next;
    logic [FW-1:0]         cur_floor_next;
    logic [NUM_FLOORS-1:0] pending_next;
    logic [CW-1:0]         door_cnt, door_cnt_next;

    logic                  idle;
    logic                  moving;
    logic [NUM_FLOORS-1:0] cur_mask;
    logic [NUM_FLOORS-1:0] above;
    logic [NUM_FLOORS-1:0] below;
    logic [FW-1:0]         near_above;
    logic [FW-1:0]         near_below;

    assign idle   = !motor_up && !motor_down && !door_open;
    assign moving = motor_up ^ motor_down;

    // Split the pending set into floors above and below the car and find
    // the closest one on each side. The downward scan leaves the lowest
    // index above the car; the upward scan leaves the highest index below.
    always_comb begin
        cur_mask   = '0;
        above      = '0;
        below      = '0;
        near_above = '0;
        near_below = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            cur_mask[i] = (cur_floor == FW'(i));
            above[i]    = pending[i] && (FW'(i) > cur_floor);
            below[i]    = pending[i] && (FW'(i) < cur_floor);
        end
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (above[i]) near_above = FW'(i);
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (below[i]) near_below = FW'(i);
        end
    end

    // SCAN dispatch: keep going the way we last went while there is work
    // on that side, otherwise turn around. Only issued while idle.
    always_comb begin
        UP   = 1'b0;
        DOWN = 1'b0;
        if (idle) begin
            if (dir == DIR_UP) begin
                if (|above)      UP   = 1'b1;
                else if (|below) DOWN = 1'b1;
            end else begin
                if (|below)      DOWN = 1'b1;
                else if (|above) UP   = 1'b1;
            end
        end
    end

    assign EQ = target_valid && moving && (cur_floor == target);
    assign T  = door_open && !door_hold && (door_cnt == CNT_MAX);

    // Next-state logic. While moving, the target is re-aimed every cycle
    // at the nearest call still ahead so en-route calls are picked up.
    // An open door both drops the target and clears the call for this
    // floor, and that clear beats a same-cycle button press here.
    always_comb begin
        dir_next          = dir;
        target_next       = target;
        target_valid_next = target_valid;
        cur_floor_next    = cur_floor;
        door_cnt_next     = door_cnt;

        if (UP) begin
            dir_next          = DIR_UP;
            target_next       = near_above;
            target_valid_next = 1'b1;
        end else if (DOWN) begin
            dir_next          = DIR_DOWN;
            target_next       = near_below;
            target_valid_next = 1'b1;
        end else if (moving) begin
            if (motor_up && |above)         target_next = near_above;
            else if (motor_down && |below)  target_next = near_below;
        end
        if (door_open) target_valid_next = 1'b0;

        pending_next = pending | (req & ~({NUM_FLOORS{idle || door_open}} & cur_mask));
        if (door_open) pending_next = pending_next & ~cur_mask;

        if (floor_tick && moving) begin
            if (motor_up && (cur_floor != TOP_FLOOR))
                cur_floor_next = cur_floor + FW'(1);
            else if (motor_down && (cur_floor != '0))
                cur_floor_next = cur_floor - FW'(1);
        end

        // The counter sits at zero while the door is shut, so the first
        // open cycle sees zero; it parks at the top value while T is high.
        if (!door_open || door_hold)  door_cnt_next = '0;
        else if (door_cnt != CNT_MAX) door_cnt_next = door_cnt + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir          <= DIR_UP;
            target       <= '0;
            target_valid <= 1'b0;
            cur_floor    <= '0;
            pending      <= '0;
            door_cnt     <= '0;
        end else begin
            dir          <= dir_next;
            target       <= target_next;
            target_valid <= target_valid_next;
            cur_floor    <= cur_floor_next;
            pending      <= pending_next;
            door_cnt     <= door_cnt_next;
        end
    end

endmodule

// File: tb/tb_elevator_request_ctrl.sv
// tb_elevator_request_ctrl
//
// Self-checking bench for elevator_request_ctrl (NUM_FLOORS=4, DOOR_CYCLES=8).
// The bench plays the elevator FSM by driving the motor/door feedback by
// hand. Each stimulus cycle pushes the expected output status onto a
// scoreboard queue; a negedge monitor pops it and compares.
// Status word: {UP, DOWN, EQ, T, cur_floor[1:0], pending[3:0]}.

module tb_elevator_request_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       floor_tick;
    logic       door_hold;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;
    logic       UP;
    logic       DOWN;
    logic       EQ;
    logic       T;
    logic [1:0] cur_floor;
    logic [3:0] pending;

    logic [9:0] status;

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    sb_entry_t mon_e;
    int        checks = 0;
    int        passes = 0;

    elevator_request_ctrl #(
        .NUM_FLOORS (4),
        .FW         (2),
        .DOOR_CYCLES(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .floor_tick(floor_tick),
        .door_hold (door_hold),
        .motor_up  (motor_up),
        .motor_down(motor_down),
        .door_open (door_open),
        .UP        (UP),
        .DOWN      (DOWN),
        .EQ        (EQ),
        .T         (T),
        .cur_floor (cur_floor),
        .pending   (pending)
    );

    assign status = {UP, DOWN, EQ, T, cur_floor, pending};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [9:0] st(input logic up, input logic dn, input logic eq,
                                      input logic t, input logic [1:0] cf,
                                      input logic [3:0] pd);
        return {up, dn, eq, t, cf, pd};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    endtask

    // Drive one cycle of inputs and queue the outputs expected before the next edge.
    task automatic applyStimulus(input string tag, input logic [3:0] r, input logic tk,
                                 input logic hd, input logic mu, input logic md,
                                 input logic dop, input logic [9:0] exp);
        sb_entry_t e;
        req        = r;
        floor_tick = tk;
        door_hold  = hd;
        motor_up   = mu;
        motor_down = md;
        door_open  = dop;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        req        = 4'b0000;
        floor_tick = 1'b0;
        door_hold  = 1'b0;
        motor_up   = 1'b0;
        motor_down = 1'b0;
        door_open  = 1'b0;
    endtask

    // Scoreboard monitor: compares mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            checkOutput(mon_e.tag, {6'd0, status}, {6'd0, mon_e.exp});
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clearInputs();
        reset = 1'b1;
        #2;
        checkOutput("reset_async", {6'd0, status}, 16'd0);
        @(posedge clk);
        #1;
        req = 4'b1111;
        @(posedge clk);
        #1;
        checkOutput("reset_req_ignored", {6'd0, status}, 16'd0);
        req   = 4'b0000;
        reset = 1'b0;

        // Call to floor 2, travel up two floors, arrive.
        applyStimulus("a_req",   4'b0100, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 2'd0, 4'b0000));
        applyStimulus("a_up",    4'b0000, 0, 0, 0, 0, 0, st(1, 0, 0, 0, 2'd0, 4'b0100));
        applyStimulus("a_start", 4'b0000, 0, 0, 1, 0, 0, st(0, 0, 0, 0, 2'd0, 4'b0100));
        applyStimulus("a_tick1", 4'b0000, 1, 0, 1, 0, 0, st(0, 0, 0, 0, 2'd0, 4'b0100));
        applyStimulus("a_mid",   4'b0000, 0, 0, 1, 0, 0, st(0, 0, 0, 0, 2'd1, 4'b0100));
        applyStimulus("a_tick2", 4'b0000, 1, 0, 1, 0, 0, st(0, 0, 0, 0, 2'd1, 4'b0100));
        applyStimulus("a_eq",    4'b0000, 0, 0, 1, 0, 0, st(0, 0, 1, 0, 2'd2, 4'b0100));

        // Door at floor 2: call clears on first edge, T on the 8th cycle and stays.
        for (int k = 1; k <= 9; k++)
            applyStimulus($sformatf("a_door%0d", k), (k == 3) ? 4'b0100 : 4'b0000,
                          0, 0, 0, 0, 1,
                          st(0, 0, 0, (k >= 8), 2'd2, (k == 1) ? 4'b0100 : 4'b0000));
        applyStimulus("a_closed", 4'b0000, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 2'd2, 4'b0000));

        // Door hold on cycle 5 pushes T out to cycle 13.
        for (int k = 1; k <= 14; k++)
            applyStimulus($sformatf("h_door%0d", k), 4'b0000, 0, (k == 5), 0, 0, 1,
                          st(0, 0, 0, (k >= 13), 2'd2, 4'b0000));
        applyStimulus("h_closed", 4'b0000, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 2'd2, 4'b0000));

        // Idle corner cases: own-floor call discarded, ticks ignored.
        applyStimulus("b_req_cur",   4'b0100, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 2'd2, 4'b0000));
        applyStimulus("b_discard",   4'b0000, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 2'd2, 4'b0000));
        applyStimulus("b_tick_idle", 4'b0000, 1, 0, 0, 0, 0, st(0, 0, 0, 0, 2'd2, 4'b0000));
        applyStimulus("b_tick_both", 4'b0000, 1, 0, 1, 1, 0, st(0, 0, 0, 0, 2'd2, 4'b0000));
        applyStimulus("b_after",     4'b0000, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 2'd2, 4'b0000));

        // Reset mid-travel at floor 2 with calls 1010 outstanding.
        applyStimulus("r_req",  4'b1010, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 2'd2, 4'b0000));
        applyStimulus("r_up",   4'b0000, 0, 0, 0, 0, 0, st(1, 0, 0, 0, 2'd2, 4'b1010));
        applyStimulus("r_move", 4'b0000, 0, 0, 1, 0, 0, st(0, 0, 0, 0, 2'd2, 4'b1010));
        clearInputs();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("r_async", {6'd0, status}, 16'd0);
        @(posedge clk);
        #1;
        checkOutput("r_held", {6'd0, status}, 16'd0);
        reset = 1'b0;

        // En-route pickup: heading for 3, call to 2 arrives at floor 1.
        applyStimulus("d_req",     4'b1000, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 2'd0, 4'b0000));
        applyStimulus("d_up",      4'b0000, 0, 0, 0, 0, 0, st(1, 0, 0, 0, 2'd0, 4'b1000));
        applyStimulus("d_start",   4'b0000, 0, 0, 1, 0, 0, st(0, 0, 0, 0, 2'd0, 4'b1000));
        applyStimulus("d_tick1",   4'b0000, 1, 0, 1, 0, 0, st(0, 0, 0, 0, 2'd0, 4'b1000));
        applyStimulus("d_req_mid", 4'b0100, 0, 0, 1, 0, 0, st(0, 0, 0, 0, 2'd1, 4'b1000));
        applyStimulus("d_retgt",   4'b0000, 0, 0, 1, 0, 0, st(0, 0, 0, 0, 2'd1, 4'b1100));
        applyStimulus("d_tick2",   4'b0000, 1, 0, 1, 0, 0, st(0, 0, 0, 0, 2'd1, 4'b1100));
        applyStimulus("d_eq2",     4'b0000, 0, 0, 1, 0, 0, st(0, 0, 1, 0, 2'd2, 4'b1100));
        applyStimulus("d_door2",   4'b0000, 0, 0, 0, 0, 1, st(0, 0, 0, 0, 2'd2, 4'b1100));
        applyStimulus("d_up3",     4'b0000, 0, 0, 0, 0, 0, st(1, 0, 0, 0, 2'd2, 4'b1000));
        applyStimulus("d_go",      4'b0000, 0, 0, 1, 0, 0, st(0, 0, 0, 0, 2'd2, 4'b1000));
        applyStimulus("d_tick3",   4'b0000, 1, 0, 1, 0, 0, st(0, 0, 0, 0, 2'd2, 4'b1000));
        applyStimulus("d_eq3",     4'b0000, 0, 0, 1, 0, 0, st(0, 0, 1, 0, 2'd3, 4'b1000));
        applyStimulus("d_sat",     4'b0000, 1, 0, 1, 0, 0, st(0, 0, 1, 0, 2'd3, 4'b1000));
        applyStimulus("d_sat_chk", 4'b0000, 0, 0, 1, 0, 0, st(0, 0, 1, 0, 2'd3, 4'b1000));
        applyStimulus("d_door3",   4'b0000, 0, 0, 0, 0, 1, st(0, 0, 0, 0, 2'd3, 4'b1000));
        applyStimulus("d_idle",    4'b0000, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 2'd3, 4'b0000));

        // Fresh start, go to floor 1 heading up.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus("c_req1",  4'b0010, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 2'd0, 4'b0000));
        applyStimulus("c_up1",   4'b0000, 0, 0, 0, 0, 0, st(1, 0, 0, 0, 2'd0, 4'b0010));
        applyStimulus("c_go1",   4'b0000, 0, 0, 1, 0, 0, st(0, 0, 0, 0, 2'd0, 4'b0010));
        applyStimulus("c_tick1", 4'b0000, 1, 0, 1, 0, 0, st(0, 0, 0, 0, 2'd0, 4'b0010));
        applyStimulus("c_eq1",   4'b0000, 0, 0, 1, 0, 0, st(0, 0, 1, 0, 2'd1, 4'b0010));
        applyStimulus("c_door1", 4'b0000, 0, 0, 0, 0, 1, st(0, 0, 0, 0, 2'd1, 4'b0010));

        // SCAN at floor 1 heading up with calls 0 and 3: up first, then down.
        applyStimulus("c_req2",  4'b1001, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 2'd1, 4'b0000));
        applyStimulus("c_up2",   4'b0000, 0, 0, 0, 0, 0, st(1, 0, 0, 0, 2'd1, 4'b1001));
        applyStimulus("c_go2",   4'b0000, 0, 0, 1, 0, 0, st(0, 0, 0, 0, 2'd1, 4'b1001));
        applyStimulus("c_tick2", 4'b0000, 1, 0, 1, 0, 0, st(0, 0, 0, 0, 2'd1, 4'b1001));
        applyStimulus("c_mid2",  4'b0000, 0, 0, 1, 0, 0, st(0, 0, 0, 0, 2'd2, 4'b1001));
        applyStimulus("c_tick3", 4'b0000, 1, 0, 1, 0, 0, st(0, 0, 0, 0, 2'd2, 4'b1001));
        applyStimulus("c_eq3",   4'b0000, 0, 0, 1, 0, 0, st(0, 0, 1, 0, 2'd3, 4'b1001));
        applyStimulus("c_door3", 4'b0000, 0, 0, 0, 0, 1, st(0, 0, 0, 0, 2'd3, 4'b1001));
        applyStimulus("c_down",  4'b0000, 0, 0, 0, 0, 0, st(0, 1, 0, 0, 2'd3, 4'b0001));
        applyStimulus("c_godn",  4'b0000, 0, 0, 0, 1, 0, st(0, 0, 0, 0, 2'd3, 4'b0001));
        for (int f = 3; f >= 1; f--) begin
            applyStimulus($sformatf("c_dtick%0d", f), 4'b0000, 1, 0, 0, 1, 0,
                          st(0, 0, 0, 0, 2'(f), 4'b0001));
            applyStimulus($sformatf("c_dat%0d", f - 1), 4'b0000, 0, 0, 0, 1, 0,
                          st(0, 0, (f == 1), 0, 2'(f - 1), 4'b0001));
        end
        applyStimulus("c_sat0",  4'b0000, 1, 0, 0, 1, 0, st(0, 0, 1, 0, 2'd0, 4'b0001));
        applyStimulus("c_sat0b", 4'b0000, 0, 0, 0, 1, 0, st(0, 0, 1, 0, 2'd0, 4'b0001));
        applyStimulus("c_door0", 4'b0000, 0, 0, 0, 0, 1, st(0, 0, 0, 0, 2'd0, 4'b0001));
        applyStimulus("c_idle",  4'b0000, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 2'd0, 4'b0000));

        checkOutput("sb_drain", 16'(sb.size()), 16'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
